fsk_decoder: RTL
================

// Module: fsk_decoder
// PURPOSE
//  Receive-side counterpart of the FSK encoder: recovers the binary code stream from a 1-bit FSK line.
//  Mark ('1') is a square wave of half-period MARK_RUN clocks; space ('0') has half-period SPACE_RUN clocks.
//  Measures run lengths between line transitions, classifies each run, debounces by run agreement.
//  Sits between the line input pin and the Hamming decoder; flags carrier presence and per-run symbol errors.
// PARAMETERS
//  MARK_RUN       4   nominal run length (clk cycles) of a '1' carrier half-period
//  SPACE_RUN      8   nominal run length of a '0' carrier half-period
//  TOL            1   accepted +/- deviation on run length; MARK_RUN+TOL < SPACE_RUN-TOL required
//  CONFIRM_RUNS   2   consecutive same-class runs required before codeout updates (>=1)
//  SILENCE_CYCLES 12  cycles without a transition that declare loss of carrier (> SPACE_RUN+TOL)
//  MAX_ERR        3   consecutive invalid runs in TRACK that force re-acquisition
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  reset       in   1  asynchronous, active-low reset
//  FSKin       in   1  FSK line, asynchronous to clk; idle level 0
//  codeout     out  1  decoded code bit (holds last confirmed value)
//  code_valid  out  1  one-cycle pulse: codeout confirmed by current run
//  receiving   out  1  carrier present (state ACQ or TRACK)
//  sym_err     out  1  one-cycle pulse: completed run outside both tolerance windows
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, state IDLE, counters 0, sync flops 0, class history cleared.
//  Input: 2-flop synchronizer, then registered edge detect (edge = sync2 ^ sync_prev).
//  Run counter: width $clog2(SILENCE_CYCLES+1); set to 1 on edge, else increments, saturates at SILENCE_CYCLES.
//  Run length L = counter value in the cycle an edge is detected (an ideal mark run gives L=4, space L=8).
//  Class: |L-MARK_RUN|<=TOL -> MARK; |L-SPACE_RUN|<=TOL -> SPACE; else INVALID.
//  Latency: code_valid/sym_err register the edge-detect cycle result -> 4 clk after FSKin change at pin.
//  FSM:
//   IDLE : receiving=0. Any edge -> ACQ; that first run start is unmeasurable, no class emitted.
//   ACQ  : receiving=1. Edge with valid class -> push to history, TRACK. INVALID -> sym_err, stay ACQ.
//   TRACK: edge with valid class -> push history; if last CONFIRM_RUNS classes equal: codeout<=class,
//          code_valid=1. INVALID -> sym_err=1, history cleared, err_cnt++; err_cnt==MAX_ERR -> ACQ.
//          Any valid run clears err_cnt.
//   ACQ/TRACK: counter reaching SILENCE_CYCLES with no edge -> IDLE, receiving<=0 same edge, history cleared.
//  codeout never changes outside a code_valid cycle; holds across silence and IDLE.
//  Edge and silence in same cycle impossible (edge resets counter); edge wins by construction.
//  Mixed runs at bit boundaries (encoder switches carrier mid-run) are expected to be INVALID or
//   misclassified singly; CONFIRM_RUNS>=2 suppresses them.
//  code_valid and sym_err never assert in the same cycle.
//  Reset mid-operation: immediate clear, next edge after release treated as from IDLE.
// STRUCTURE
//  Package fsk_pkg: MARK_RUN/SPACE_RUN defaults, run_class_t {MARK, SPACE, INVALID},
//   dec_state_t {IDLE, ACQ, TRACK}; shared with the encoder's carrier constants.
//  Sub-module fsk_run_meter: synchronizer + edge detect + saturating run counter;
//   outputs edge pulse, run length L, silence flag. Classifier, history and FSM stay in fsk_decoder.
// TESTING
//  Reset: hold reset=0, toggle FSKin randomly -> codeout=receiving=code_valid=sym_err=0 throughout.
//  Mark: FSKin square wave 4 high/4 low x10 -> receiving=1, first code_valid after 3rd edge, then every 4 clk, codeout=1.
//  Space after mark: switch to 8/8 wave mid-run -> at most one sym_err, codeout 1->0 on 2nd space run, valid every 8 clk.
//  Jitter: runs 3,5,4,5 -> all MARK, no sym_err; runs 6,10 -> sym_err each; 3 invalid in TRACK -> back to ACQ.
//  Silence: drop carrier, FSKin=0 for 20 clk -> receiving falls 12 clk after last edge, codeout holds.
//  Reset mid-TRACK: pulse reset=0 one cycle -> outputs clear at once; re-acquire on resumed 4/4 wave.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared FSK carrier constants and the decoder's run-class / state types.
package fsk_pkg;

  localparam int DEF_MARK_RUN  = 4;
  localparam int DEF_SPACE_RUN = 8;

  typedef enum logic [1:0] {MARK, SPACE, INVALID} run_class_t;
  typedef enum logic [1:0] {IDLE, ACQ, TRACK} dec_state_t;

  // A run belongs to a carrier class when it lies within +/- tol of that class's nominal length.
  function automatic run_class_t classify(input int len, input int mark_run,
                                          input int space_run, input int tol);
    run_class_t cls;
    cls = INVALID;
    if (len >= mark_run - tol && len <= mark_run + tol) begin
      cls = MARK;
    end else if (len >= space_run - tol && len <= space_run + tol) begin
      cls = SPACE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fsk_run_meter.sv
// Line synchronizer, registered transition detect and saturating run-length counter.
module fsk_run_meter #(
  parameter int SILENCE_CYCLES = 12,
  parameter int CW             = $clog2(SILENCE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          line_i,
  output logic          edge_o,
  output logic [CW-1:0] run_len_o,
  output logic          silence_o
);

  localparam logic [CW-1:0] SIL_MAX = CW'(SILENCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic          edge_q, edge_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = line_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_d  = sync2_q ^ prev_q;
    // The counter restarts at 1 so that it reads exactly L in the cycle the next edge is seen.
    if (edge_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q == SIL_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
    end
  end

  assign edge_o    = edge_q;
  assign run_len_o = cnt_q;
  assign silence_o = !edge_q && (cnt_q == SIL_MAX);

endmodule

// File: rtl/fsk_decoder.sv
// FSK line decoder: classifies carrier half-period runs and confirms a code bit after
// CONFIRM_RUNS agreeing runs; tracks carrier presence and per-run symbol errors.
module fsk_decoder
  import fsk_pkg::*;
#(
  parameter int MARK_RUN       = DEF_MARK_RUN,
  parameter int SPACE_RUN      = DEF_SPACE_RUN,
  parameter int TOL            = 1,
  parameter int CONFIRM_RUNS   = 2,
  parameter int SILENCE_CYCLES = 12,
  parameter int MAX_ERR        = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic FSKin,
  output logic codeout,
  output logic code_valid,
  output logic receiving,
  output logic sym_err
);

  localparam int CW = $clog2(SILENCE_CYCLES + 1);
  localparam int EW = $clog2(MAX_ERR + 1);
  localparam logic [CONFIRM_RUNS-1:0][1:0] HIST_CLR = {CONFIRM_RUNS{INVALID}};

  logic          run_edge;
  logic [CW-1:0] run_len;
  logic          silence;

  fsk_run_meter #(
    .SILENCE_CYCLES(SILENCE_CYCLES),
    .CW            (CW)
  ) u_meter (
    .clk      (clk),
    .rst_n    (reset),
    .line_i   (FSKin),
    .edge_o   (run_edge),
    .run_len_o(run_len),
    .silence_o(silence)
  );

  dec_state_t                     state_q, state_d;
  logic [CONFIRM_RUNS-1:0][1:0]   hist_q, hist_d, hist_push;
  logic [EW-1:0]                  err_cnt_q, err_cnt_d;
  logic                           codeout_q, codeout_d;
  logic                           code_valid_q, code_valid_d;
  logic                           sym_err_q, sym_err_d;
  run_class_t                     run_cls;
  logic                           run_match;

  // History holds INVALID in unfilled slots, so "all slots equal" implies enough agreeing runs.
  always_comb begin
    run_cls   = classify(int'(run_len), MARK_RUN, SPACE_RUN, TOL);
    hist_push = hist_q;
    for (int i = CONFIRM_RUNS - 1; i > 0; i--) begin
      hist_push[i] = hist_q[i-1];
    end
    hist_push[0] = run_cls;
    run_match = 1'b1;
    for (int i = 0; i < CONFIRM_RUNS; i++) begin
      if (hist_push[i] != run_cls) run_match = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    err_cnt_d    = err_cnt_q;
    codeout_d    = codeout_q;
    code_valid_d = 1'b0;
    sym_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_edge) begin
          state_d   = ACQ;
          hist_d    = HIST_CLR;
          err_cnt_d = '0;
        end
      end
      ACQ: begin
        if (run_edge) begin
          if (run_cls == INVALID) begin
            sym_err_d = 1'b1;
          end else begin
            hist_d    = hist_push;
            err_cnt_d = '0;
            state_d   = TRACK;
          end
        end else if (silence) begin
          state_d   = IDLE;
          hist_d    = HIST_CLR;
          err_cnt_d = '0;
        end
      end
      TRACK: begin
        if (run_edge) begin
          if (run_cls == INVALID) begin
            sym_err_d = 1'b1;
            hist_d    = HIST_CLR;
            if (err_cnt_q == EW'(MAX_ERR - 1)) begin
              state_d   = ACQ;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q + EW'(1);
            end
          end else begin
            hist_d    = hist_push;
            err_cnt_d = '0;
            if (run_match) begin
              codeout_d    = (run_cls == MARK);
              code_valid_d = 1'b1;
            end
          end
        end else if (silence) begin
          state_d   = IDLE;
          hist_d    = HIST_CLR;
          err_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hist_d  = HIST_CLR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hist_q       <= HIST_CLR;
      err_cnt_q    <= '0;
      codeout_q    <= 1'b0;
      code_valid_q <= 1'b0;
      sym_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      err_cnt_q    <= err_cnt_d;
      codeout_q    <= codeout_d;
      code_valid_q <= code_valid_d;
      sym_err_q    <= sym_err_d;
    end
  end

  assign codeout    = codeout_q;
  assign code_valid = code_valid_q;
  assign sym_err    = sym_err_q;
  assign receiving  = (state_q != IDLE);

endmodule
